// File: rtl/ds_mod_multich.sv
// ds_mod_multich
// Time-multiplexed error-feedback delta-sigma modulator. Each tick starts one
// frame, and the frame visits every channel round-robin. A channel slot lasts
// MAX_ORDER+2 cycles, and all slots share one accumulator adder:
//   S0          acc = sample + dither
//   S1..SMAX    acc += c_k * e_k   (binomial NTF taps, shift/add only)
//   S(MAX+1)    quantise, saturate, emit y, push the new error into history
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  frame start strobe (ignored while busy, sets overrun)
//   wr_en/wr_ch/wr_data   sample register write
//   order_cfg             2-bit noise-shaping order per channel
//   dither_en             per-channel LFSR dither enable
//   clear_hist            zero all error history (idle only)
//   flag_clr              clear sticky flags
//   busy                  frame in progress
//   y_valid/y_ch/y        one-cycle output strobe, channel, output code
//   sat_flag              sticky: an output was clamped
//   overrun_flag          sticky: tick arrived while busy
module ds_mod_multich #(
  parameter int          NUM_CH      = 4,
  parameter int          CH_BITS     = 2,
  parameter int          IN_BITS     = 16,
  parameter int          FRAC_BITS   = 11,
  parameter int          OUT_BITS    = 5,
  parameter int          MAX_ORDER   = 3,
  parameter int          DITHER_BITS = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  wr_en,
  input  logic [CH_BITS-1:0]    wr_ch,
  input  logic [IN_BITS-1:0]    wr_data,
  input  logic [2*NUM_CH-1:0]   order_cfg,
  input  logic [NUM_CH-1:0]     dither_en,
  input  logic                  clear_hist,
  input  logic                  flag_clr,
  output logic                  busy,
  output logic                  y_valid,
  output logic [CH_BITS-1:0]    y_ch,
  output logic [OUT_BITS-1:0]   y,
  output logic                  sat_flag,
  output logic                  overrun_flag
);

  localparam int ACC_BITS = IN_BITS + 4;
  localparam int SLOT_W   = $clog2(MAX_ORDER + 2);
  localparam logic [SLOT_W-1:0]          SLOT_LAST = SLOT_W'(MAX_ORDER + 1);
  localparam logic [CH_BITS-1:0]         CH_LAST   = CH_BITS'(NUM_CH - 1);
  localparam logic [2:0]                 ORD_MAX   = 3'(MAX_ORDER);
  localparam logic signed [ACC_BITS-1:0] Y_MAX     = ACC_BITS'((1 << OUT_BITS) - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                        r_state, w_state_nxt;
  logic [CH_BITS-1:0]            r_ch;
  logic [SLOT_W-1:0]             r_slot;
  logic [1:0]                    r_ord;
  logic [15:0]                   r_lfsr;
  logic signed [ACC_BITS-1:0]    r_acc;
  logic [IN_BITS-1:0]            r_sample [NUM_CH];
  logic signed [FRAC_BITS-1:0]   r_hist   [NUM_CH][MAX_ORDER];
  logic                          r_y_valid, r_sat, r_ovr;
  logic [CH_BITS-1:0]            r_y_ch;
  logic [OUT_BITS-1:0]           r_y;

  logic                          w_run, w_s0, w_fin;
  logic [2:0]                    w_cfg_ord;
  logic [1:0]                    w_eff_ord;
  logic signed [ACC_BITS-1:0]    w_add_a, w_add_b, w_sum, w_q;
  logic [OUT_BITS:0]             w_sat_y;
  logic signed [FRAC_BITS-1:0]   w_e_new;

  // Tap k contribution for a given order: coefficients of (1-z^-1)^order
  // with the leading 1 removed and sign flipped, built from shifts and adds.
  function automatic logic signed [ACC_BITS-1:0] tap_term(
    input logic [1:0] ord, input int k, input logic signed [FRAC_BITS-1:0] e);
    logic signed [ACC_BITS-1:0] ex, ex3;
    ex  = {{(ACC_BITS-FRAC_BITS){e[FRAC_BITS-1]}}, e};
    ex3 = (ex <<< 1) + ex;
    tap_term = '0;
    case (ord)
      2'd1: if (k == 1) tap_term = ex;
      2'd2: if (k == 1) tap_term = ex <<< 1; else if (k == 2) tap_term = -ex;
      2'd3: if (k == 1) tap_term = ex3; else if (k == 2) tap_term = -ex3;
            else if (k == 3) tap_term = ex;
      default: tap_term = '0;
    endcase
  endfunction

  // Returns {clamped, code}: quotient clamped to [0, 2^OUT_BITS-1].
  function automatic logic [OUT_BITS:0] sat_out(input logic signed [ACC_BITS-1:0] q);
    if (q[ACC_BITS-1])  sat_out = {1'b1, {OUT_BITS{1'b0}}};
    else if (q > Y_MAX) sat_out = {1'b1, {OUT_BITS{1'b1}}};
    else                sat_out = {1'b0, q[OUT_BITS-1:0]};
  endfunction

  assign w_run     = (r_state == ST_RUN);
  assign w_s0      = w_run && (r_slot == '0);
  assign w_fin     = w_run && (r_slot == SLOT_LAST);
  assign w_cfg_ord = {1'b0, order_cfg[{r_ch, 1'b0} +: 2]};
  assign w_eff_ord = (w_cfg_ord > ORD_MAX) ? ORD_MAX[1:0] : w_cfg_ord[1:0];
  assign w_q       = r_acc >>> FRAC_BITS;
  assign w_sat_y   = sat_out(w_q);
  // Flipping the top fraction bit subtracts 2^(FRAC_BITS-1) modulo 2^FRAC_BITS.
  assign w_e_new   = {~r_acc[FRAC_BITS-1], r_acc[FRAC_BITS-2:0]};

  // Shared adder operand select: S0 loads sample+dither, later slots add a tap.
  always_comb begin
    w_add_a = r_acc;
    w_add_b = '0;
    for (int k = 1; k <= MAX_ORDER; k++) begin
      if (r_slot == SLOT_W'(k)) w_add_b = tap_term(r_ord, k, r_hist[r_ch][k-1]);
    end
    if (r_slot == '0) begin
      w_add_a = $signed({{(ACC_BITS-IN_BITS){1'b0}}, r_sample[r_ch]});
      if (dither_en[r_ch])
        w_add_b = {{(ACC_BITS-DITHER_BITS){r_lfsr[DITHER_BITS-1]}}, r_lfsr[DITHER_BITS-1:0]};
    end
  end
  assign w_sum = w_add_a + w_add_b;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (tick) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fin && (r_ch == CH_LAST)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_slot <= '0;
      r_ord  <= '0;
      r_lfsr <= LFSR_SEED;
      r_acc  <= '0;
    end else if (!w_run) begin
      r_ch   <= '0;
      r_slot <= '0;
    end else begin
      if (w_fin) begin
        r_slot <= '0;
        r_ch   <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
        r_acc  <= w_sum;
      end
      if (w_s0) begin
        r_ord  <= w_eff_ord;
        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_sample[c] <= '0;
    end else if (wr_en && ({{(32-CH_BITS){1'b0}}, wr_ch} < NUM_CH)) begin
      r_sample[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < MAX_ORDER; k++) r_hist[c][k] <= '0;
    end else if (!w_run && clear_hist) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < MAX_ORDER; k++) r_hist[c][k] <= '0;
    end else if (w_fin) begin
      r_hist[r_ch][0] <= w_e_new;
      for (int k = 1; k < MAX_ORDER; k++) r_hist[r_ch][k] <= r_hist[r_ch][k-1];
    end
  end

  // Output strobe and sticky flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid <= 1'b0;
      r_y_ch    <= '0;
      r_y       <= '0;
      r_sat     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_y_valid <= w_fin;
      if (w_fin) begin
        r_y_ch <= r_ch;
        r_y    <= w_sat_y[OUT_BITS-1:0];
      end
      r_sat <= (w_fin && w_sat_y[OUT_BITS]) || (r_sat && !flag_clr);
      r_ovr <= (tick && w_run) || (r_ovr && !flag_clr);
    end
  end

  assign busy         = w_run;
  assign y_valid      = r_y_valid;
  assign y_ch         = r_y_ch;
  assign y            = r_y;
  assign sat_flag     = r_sat;
  assign overrun_flag = r_ovr;

endmodule

// File: tb/tb_ds_mod_multich.sv
module tb_ds_mod_multich;
  localparam int NUM_CH = 4, CH_BITS = 2, IN_BITS = 16, FRAC_BITS = 11;
  localparam int OUT_BITS = 5, MAX_ORDER = 3, DITHER_BITS = 4;
  localparam int SLOT = MAX_ORDER + 2;

  logic                clk, rst_n, tick, wr_en, clear_hist, flag_clr;
  logic [CH_BITS-1:0]  wr_ch;
  logic [IN_BITS-1:0]  wr_data;
  logic [2*NUM_CH-1:0] order_cfg;
  logic [NUM_CH-1:0]   dither_en;
  logic                busy, y_valid, sat_flag, overrun_flag;
  logic [CH_BITS-1:0]  y_ch;
  logic [OUT_BITS-1:0] y;

  ds_mod_multich #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .IN_BITS(IN_BITS), .FRAC_BITS(FRAC_BITS),
    .OUT_BITS(OUT_BITS), .MAX_ORDER(MAX_ORDER), .DITHER_BITS(DITHER_BITS),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .order_cfg(order_cfg), .dither_en(dither_en),
    .clear_hist(clear_hist), .flag_clr(flag_clr), .busy(busy), .y_valid(y_valid),
    .y_ch(y_ch), .y(y), .sat_flag(sat_flag), .overrun_flag(overrun_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: per-channel integer state, NTF coefficients from binomials.
  int          m_sample [NUM_CH];
  int          m_hist   [NUM_CH][MAX_ORDER];
  logic [15:0] m_lfsr;
  bit          m_sat, m_ovr;
  int          exp_y    [NUM_CH];
  bit          exp_clamp[NUM_CH];
  int          last_y   [NUM_CH];
  int          first_y  [NUM_CH];

  function automatic int coef(input int o, input int k);
    int c;
    if (k > o) return 0;
    c = 1;
    for (int i = 1; i <= k; i++) c = c * (o - i + 1) / i;
    return (k % 2 == 1) ? c : -c;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sample[c] = 0;
      for (int k = 0; k < MAX_ORDER; k++) m_hist[c][k] = 0;
    end
    m_lfsr = 16'hACE1;
    m_sat  = 0;
    m_ovr  = 0;
  endtask

  task automatic model_clear_hist();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < MAX_ORDER; k++) m_hist[c][k] = 0;
  endtask

  task automatic model_frame(input logic [2*NUM_CH-1:0] ocfg, input logic [NUM_CH-1:0] den);
    int o, d, acc, q, e;
    for (int c = 0; c < NUM_CH; c++) begin
      o = int'(ocfg[2*c +: 2]);
      if (o > MAX_ORDER) o = MAX_ORDER;
      d = 0;
      if (den[c]) begin
        d = int'(m_lfsr[DITHER_BITS-1:0]);
        if (d >= (1 << (DITHER_BITS-1))) d -= (1 << DITHER_BITS);
      end
      m_lfsr = lfsr_next(m_lfsr);
      acc = m_sample[c] + d;
      for (int k = 1; k <= MAX_ORDER; k++) acc += coef(o, k) * m_hist[c][k-1];
      q = acc >>> FRAC_BITS;
      exp_clamp[c] = (q < 0) || (q > (1 << OUT_BITS) - 1);
      exp_y[c] = (q < 0) ? 0 : ((q > (1 << OUT_BITS) - 1) ? (1 << OUT_BITS) - 1 : q);
      e = (acc & ((1 << FRAC_BITS) - 1)) - (1 << (FRAC_BITS-1));
      for (int k = MAX_ORDER-1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = e;
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_write(input int ch, input int data);
    wr_en = 1'b1; wr_ch = CH_BITS'(ch); wr_data = IN_BITS'(data);
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    m_sample[ch] = data;
  endtask

  task automatic run_frame(input logic [2*NUM_CH-1:0] ocfg, input logic [NUM_CH-1:0] den,
                           input bit clr, input bit ovr, input int fclr_ch,
                           input bit late_wr, input int late_val, input bit rst_mid);
    int got;
    bit s;
    order_cfg = ocfg;
    dither_en = den;
    if (clr) model_clear_hist();
    model_frame(ocfg, den);
    if (fclr_ch >= 0) begin
      s = 0;
      for (int c = fclr_ch; c < NUM_CH; c++) s |= exp_clamp[c];
      m_ovr = 0;
    end else begin
      s = m_sat;
      for (int c = 0; c < NUM_CH; c++) s |= exp_clamp[c];
      m_ovr = m_ovr | ovr;
    end
    m_sat = s;
    tick = 1'b1; clear_hist = clr;
    @(posedge clk); @(negedge clk);
    tick = 1'b0; clear_hist = 1'b0;
    check_val("busy_start", busy, 1);
    if (late_wr) begin wr_en = 1'b1; wr_ch = '0; wr_data = IN_BITS'(late_val); end
    got = 0;
    for (int n = 1; n <= NUM_CH*SLOT + 1; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        wr_en = 1'b0;
        if (late_wr) m_sample[0] = late_val;
      end
      if (y_valid) begin
        if (got < NUM_CH) begin
          check_val("yv_time", n, SLOT*(got+1));
          check_val("y_ch", y_ch, got);
          check_val("y", y, exp_y[got]);
          last_y[got] = y;
        end else check_val("extra_yv", 1, 0);
        got++;
      end
      if (n == NUM_CH*SLOT) check_val("busy_end", busy, 0);
      if (ovr) begin
        if (n == 6) tick = 1'b1; else if (n == 7) tick = 1'b0;
      end
      if (fclr_ch >= 0) begin
        if (n == SLOT*fclr_ch + SLOT - 1) flag_clr = 1'b1;
        else if (n == SLOT*(fclr_ch+1)) flag_clr = 1'b0;
      end
      if (rst_mid && n == SLOT + 2) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_yv", y_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_y", y, 0);
        check_val("rst_sat", sat_flag, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check_val("yv_count", got, NUM_CH);
    check_val("sat_flag", sat_flag, m_sat);
    check_val("ovr_flag", overrun_flag, m_ovr);
  endtask

  localparam logic [2*NUM_CH-1:0] CFG_A = {2'd2, 2'd1, 2'd1, 2'd0};
  int seq[4];
  int sum, diff;

  initial begin
    rst_n = 1'b0; tick = 0; wr_en = 0; wr_ch = '0; wr_data = '0;
    order_cfg = '0; dither_en = '0; clear_hist = 0; flag_clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_yv", y_valid, 0);
    check_val("reset_y", y, 0);
    check_val("reset_ych", y_ch, 0);
    check_val("reset_sat", sat_flag, 0);
    check_val("reset_ovr", overrun_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(0, 'h2A40); do_write(1, 'h0A00); do_write(2, 'hFFFF); do_write(3, 'h4400);
    run_frame(CFG_A, '0, 0, 0, -1, 0, 0, 0);
    first_y = last_y;
    seq[0] = last_y[1];
    check_val("ch0_order0", last_y[0], 5);
    check_val("ch2_frame1", last_y[2], 31);
    check_val("sat_f1", sat_flag, 0);

    // flag_clr on the same edge as ch2's clamp: the set must win.
    run_frame(CFG_A, '0, 0, 0, 2, 0, 0, 0);
    seq[1] = last_y[1];
    check_val("ch2_clamp", last_y[2], 31);
    check_val("sat_set_wins", sat_flag, 1);

    flag_clr = 1'b1; @(posedge clk); @(negedge clk); flag_clr = 1'b0;
    m_sat = 0; m_ovr = 0;
    check_val("sat_cleared", sat_flag, 0);

    // Overrun tick mid-frame plus a write to ch0 on its own S0 edge.
    run_frame(CFG_A, '0, 0, 1, -1, 1, 'h3000, 0);
    seq[2] = last_y[1];
    check_val("overrun_set", overrun_flag, 1);
    check_val("late_wr_old", last_y[0], 5);
    run_frame(CFG_A, '0, 0, 0, -1, 0, 0, 0);
    seq[3] = last_y[1];
    check_val("late_wr_new", last_y[0], 6);
    check_val("ord1_seq0", seq[0], 1);
    check_val("ord1_seq1", seq[1], 1);
    check_val("ord1_seq2", seq[2], 0);
    check_val("ord1_seq3", seq[3], 1);

    // Idle clear_hist, then order-2 DC run.
    clear_hist = 1'b1; @(posedge clk); @(negedge clk); clear_hist = 1'b0;
    model_clear_hist();
    sum = 0;
    for (int f = 0; f < 64; f++) begin
      run_frame(CFG_A, '0, 0, 0, -1, 0, 0, 0);
      sum += last_y[3];
    end
    diff = sum - 64*8;
    if (diff < 0) diff = -diff;
    check_val("dc_mean_ord2", (diff <= 1) ? 1 : 0, 1);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        int v;
        case ($urandom_range(0, 3))
          0: v = $urandom_range(0, 2047);
          1: v = $urandom_range(63488, 65535);
          default: v = $urandom_range(0, 65535);
        endcase
        do_write($urandom_range(0, NUM_CH-1), v);
      end
      if ($urandom_range(0, 5) == 0) begin
        flag_clr = 1'b1; @(posedge clk); @(negedge clk); flag_clr = 1'b0;
        m_sat = 0; m_ovr = 0;
      end
      run_frame(2*NUM_CH'($urandom), NUM_CH'($urandom), ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 5) == 0), -1, 0, 0, 0);
    end

    // Reset mid-frame (ch1 S2), then replay the power-up frame.
    run_frame(CFG_A, '0, 0, 0, -1, 0, 0, 1);
    do_write(0, 'h2A40); do_write(1, 'h0A00); do_write(2, 'hFFFF); do_write(3, 'h4400);
    run_frame(CFG_A, '0, 0, 0, -1, 0, 0, 0);
    for (int c = 0; c < NUM_CH; c++) check_val("replay_first", last_y[c], first_y[c]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ds_mod_multich.md
Name: ds_mod_multich

Overview:
- Time-multiplexed error-feedback delta-sigma modulator serving NUM_CH independent channels through one shared adder datapath.
- Noise-shaping order is selectable per channel at run time (0..MAX_ORDER), with optional per-channel LFSR dither, output saturation and sticky status flags.
- Processes one frame (all channels, round-robin) per tick strobe.
- Sits between the sample register file and the per-channel PWM/pulse back-ends.

Parameters:
- NUM_CH, 4, number of channels.
- CH_BITS, 2, width of channel index (>= clog2(NUM_CH)).
- IN_BITS, 16, unsigned input sample width.
- FRAC_BITS, 11, fractional bits removed by quantiser.
- OUT_BITS, 5, output code width (= IN_BITS-FRAC_BITS).
- MAX_ORDER, 3, highest supported NTF order (1..3).
- DITHER_BITS, 4, width of signed dither added before quantisation.
- LFSR_SEED, 16'hACE1, LFSR value after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  frame start strobe.
- wr_en  in  1  write sample register.
- wr_ch  in  CH_BITS  channel for write.
- wr_data  in  IN_BITS  sample value.
- order_cfg  in  2*NUM_CH  2-bit order per channel, ch k at [2k+1:2k].
- dither_en  in  NUM_CH  per-channel dither enable.
- clear_hist  in  1  zero all error history (only when idle).
- flag_clr  in  1  clear sticky flags.
- busy  out  1  frame in progress.
- y_valid  out  1  one-cycle output strobe.
- y_ch  out  CH_BITS  channel of y.
- y  out  OUT_BITS  quantised output code.
- sat_flag  out  1  sticky: output saturated.
- overrun_flag  out  1  sticky: tick while busy.

Behaviour:
- Reset (async, rst_n=0):
  - busy, y_valid, y_ch, y, both flags = 0.
  - Sample registers and error history = 0.
  - LFSR = LFSR_SEED.
  - Effect is immediate, including mid-frame.
- Sample writes:
  - wr_en writes wr_data to sample[wr_ch] at the clock edge.
  - wr_ch >= NUM_CH is ignored.
  - A channel's sample, order and dither enable are read in slot cycle S0. A write on that same edge is not seen until the next frame.
- States: IDLE, RUN.
  - IDLE: tick=1 goes to RUN, ch=0, slot cycle S0, busy=1 from the next cycle.
  - RUN: each channel slot is MAX_ORDER+2 cycles, S0..S(MAX_ORDER+1). After the last channel's final slot cycle, go to IDLE (busy=0).
  - tick while busy: ignored, overrun_flag set.
- Slot datapath (single adder, signed accumulator ACC_BITS = IN_BITS+4):
  - S0: acc = u + d. d = sign-extended LFSR[DITHER_BITS-1:0] if dither_en[ch], else 0. LFSR steps once per S0 only.
  - S1..S(MAX_ORDER): add c_k*e_k for k = 1..MAX_ORDER. e_k is this channel's error from k frames ago. Taps with k > effective order add 0.
  - Effective order = min(order_cfg[ch], MAX_ORDER).
  - Coefficients: order 0: none; 1: [1]; 2: [2,-1]; 3: [3,-3,1]. Implemented by shift/add; no multiplier.
  - Final slot cycle S(MAX_ORDER+1):
    - y_valid=1, y_ch=ch.
    - y = acc >>> FRAC_BITS, clamped to [0, 2^OUT_BITS-1].
    - Any clamp sets sat_flag.
    - e = acc[FRAC_BITS-1:0] - 2^(FRAC_BITS-1), signed FRAC_BITS, taken from the unclamped acc.
    - History shifts: e_1 <= e, e_2 <= e_1, ...
- Resulting transfer: Y = U/2^F - 1/2 - (1-z^-1)^order * E.
- y and y_ch hold their values between strobes.
- Flags:
  - flag_clr clears both flags.
  - A set event on the same edge as flag_clr wins (flag stays 1).
- clear_hist:
  - Honoured only in IDLE. Zeroes all e_k.
  - Ignored while busy.
  - Coincident with tick: history is cleared and the frame starts.
- Changing order_cfg between frames keeps the existing history; no flush.

Test Plan:
- Order 0, no dither, sample[0]=0x2A40, one tick -> ch0 y=5; stored e=-448.
- Order 1, sample[1]=0x0A00, repeated ticks -> ch1 y sequence 1,1,0,1 repeating (mean 0.75); sat_flag stays 0.
- Order 1, sample[2]=0xFFFF -> frame1 y=31; frame2 acc>>11=32, clamped to y=31, sat_flag=1. flag_clr -> 0 next cycle.
- NUM_CH=4, MAX_ORDER=3, tick at edge T -> y_valid for ch0..3 at T+5, T+10, T+15, T+20 (one cycle each); busy low after T+20. Second tick at T+7 -> overrun_flag=1, frame timing unchanged.
- Order 2, DC input 0x4400, dither off, 64 frames -> mean(y) within 1/64 of 8.0; first-difference of e sequence bounded.
- rst_n pulsed low during S2 of ch1 -> y_valid, busy, y immediately 0. After release, tick re-runs ch0 from zeroed history, with output identical to the first frame after power-up.
